// File: rtl/ccff_loader_if.sv
// Byte-stream handshake into the configuration-chain loader.
interface ccff_loader_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ccff_loader.sv
// Streams bitstream bytes MSB-first into a CCFF configuration chain.
// Define CCFF_PARITY_EN to add a trailer-byte parity check and err port.
module ccff_loader #(
    parameter int unsigned CHAIN_LEN = 48
) (
    input  logic         prog_clk,
    input  logic         prog_reset,
    input  logic         start,
    ccff_loader_if.slave s_if,
    output logic         ccff_head,
    output logic         ccff_shift_en,
    output logic         busy,
`ifdef CCFF_PARITY_EN
    output logic         err,
`endif
    output logic         done
);

    localparam int unsigned CW = $clog2(CHAIN_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
`ifdef CCFF_PARITY_EN
        PAR,
`endif
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    sbuf_q, sbuf_d;
    logic [2:0]    bit_q, bit_d;
    logic [CW-1:0] tot_q, tot_d;
    logic          head_q, head_d;
    logic          ready;
`ifdef CCFF_PARITY_EN
    logic          par_q, par_d;
    logic          err_q, err_d;

    assign err = err_q;
`endif

    assign s_if.s_ready = ready;

    always_comb begin
        state_d       = state_q;
        sbuf_d        = sbuf_q;
        bit_d         = bit_q;
        tot_d         = tot_q;
        head_d        = head_q;
        ready         = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = head_q;
        busy          = (state_q != IDLE);
        done          = 1'b0;
`ifdef CCFF_PARITY_EN
        par_d         = par_q;
        err_d         = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    bit_d   = '0;
                    tot_d   = '0;
`ifdef CCFF_PARITY_EN
                    par_d   = 1'b0;
                    err_d   = 1'b0;
`endif
                end
            end
            LOAD: begin
                ready = 1'b1;
                if (s_if.s_valid) begin
                    sbuf_d  = s_if.s_data;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ccff_shift_en = 1'b1;
                ccff_head     = sbuf_q[7];
                head_d        = sbuf_q[7];
                sbuf_d        = {sbuf_q[6:0], 1'b0};
                bit_d         = bit_q + 3'd1;
                tot_d         = tot_q + CW'(1);
`ifdef CCFF_PARITY_EN
                par_d         = par_q ^ sbuf_q[7];
`endif
                // Chain end wins over byte end: leftover low bits are dropped.
                if (tot_d == CW'(CHAIN_LEN)) begin
`ifdef CCFF_PARITY_EN
                    state_d = PAR;
`else
                    state_d = DONE;
`endif
                end else if (bit_q == 3'd7) begin
                    state_d = LOAD;
                end
            end
`ifdef CCFF_PARITY_EN
            PAR: begin
                ready = 1'b1;
                if (s_if.s_valid) begin
                    if (s_if.s_data[0] != par_q) begin
                        err_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q <= IDLE;
            sbuf_q  <= '0;
            bit_q   <= '0;
            tot_q   <= '0;
            head_q  <= 1'b0;
`ifdef CCFF_PARITY_EN
            par_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sbuf_q  <= sbuf_d;
            bit_q   <= bit_d;
            tot_q   <= tot_d;
            head_q  <= head_d;
`ifdef CCFF_PARITY_EN
            par_q   <= par_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: one 8-bit and one 12-bit chain instance.
// Parity checks are compiled in only with CCFF_PARITY_EN.
module tb_ccff_loader;

`ifdef CCFF_PARITY_EN
    localparam int NB8  = 2;
    localparam int NB12 = 3;
`else
    localparam int NB8  = 1;
    localparam int NB12 = 2;
`endif

    logic prog_clk;
    logic prog_reset;
    logic start8, start12;
    logic head8, sh8, busy8, done8;
    logic head12, sh12, busy12, done12;
`ifdef CCFF_PARITY_EN
    logic err8, err12;
`endif

    ccff_loader_if i8 ();
    ccff_loader_if i12 ();

    ccff_loader #(.CHAIN_LEN(8)) u8 (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start         (start8),
        .s_if          (i8),
        .ccff_head     (head8),
        .ccff_shift_en (sh8),
        .busy          (busy8),
`ifdef CCFF_PARITY_EN
        .err           (err8),
`endif
        .done          (done8)
    );

    ccff_loader #(.CHAIN_LEN(12)) u12 (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start         (start12),
        .s_if          (i12),
        .ccff_head     (head12),
        .ccff_shift_en (sh12),
        .busy          (busy12),
`ifdef CCFF_PARITY_EN
        .err           (err12),
`endif
        .done          (done12)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // exp = {busy, s_ready, shift_en, head, done}
    typedef struct {
        logic       st;
        logic       vld;
        logic [7:0] dat;
        logic [4:0] exp;
    } vec_t;

    vec_t tv[$];
    int   total;
    int   bad;
    logic [7:0] b12 [3];

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic vld,
                       input logic [7:0] dat, input logic [4:0] exp);
        vec_t v;
        v.st  = st;
        v.vld = vld;
        v.dat = dat;
        v.exp = exp;
        tv.push_back(v);
    endtask

    task automatic load8(input logic [7:0] b, input logic [7:0] tr,
                         output logic [7:0] bits, output int n,
                         output int dn);
        int acc;
        acc  = 0;
        n    = 0;
        dn   = 0;
        bits = '0;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            i8.s_valid = (acc < NB8);
            i8.s_data  = (acc == 0) ? b : tr;
            if (sh8) begin
                bits = {bits[6:0], head8};
                n++;
            end
            if (done8) dn++;
            if (i8.s_ready && i8.s_valid) acc++;
            step();
        end
        i8.s_valid = 1'b0;
    endtask

    task automatic run12(input int stall, input string tag);
        int idx, st, n, gap, hold_bad, dn;
        logic [11:0] bits;
        logic prev;
        idx = 0; st = 0; n = 0; gap = 0;
        hold_bad = 0; dn = 0; bits = '0;
        prev = head12;
        start12 = 1'b1;
        step();
        start12 = 1'b0;
        for (int c = 0; c < 45; c++) begin
            if (idx == 1 && i12.s_ready && st < stall) begin
                i12.s_valid = 1'b0;
                st++;
            end else if (idx < NB12) begin
                i12.s_valid = 1'b1;
                i12.s_data  = b12[idx];
            end else begin
                i12.s_valid = 1'b0;
            end
            if (sh12) begin
                bits = {bits[10:0], head12};
                n++;
            end else begin
                if (head12 !== prev) hold_bad++;
                if (n > 0 && n < 12) gap++;
            end
            prev = head12;
            if (done12) dn++;
            if (i12.s_ready && i12.s_valid) idx++;
            step();
        end
        i12.s_valid = 1'b0;
        chk({tag, "_shifts"}, n, 12);
        chk({tag, "_bits"}, {20'd0, bits}, 32'hFF3);
        chk({tag, "_done_cnt"}, dn, 1);
        chk({tag, "_gap"}, gap, stall + 1);
        chk({tag, "_head_hold"}, hold_bad, 0);
        chk({tag, "_idle"}, busy12, 1'b0);
    endtask

    initial begin
        logic [7:0] bits;
        int n, dn;
        total = 0;
        bad   = 0;
        b12[0] = 8'hFF;
        b12[1] = 8'h3C;
        b12[2] = 8'h00;
        start8 = 1'b0;
        start12 = 1'b0;
        i8.s_valid = 1'b0;
        i8.s_data = 8'h00;
        i12.s_valid = 1'b0;
        i12.s_data = 8'h00;

        // Byte 0xA5 into the 8-bit chain, with ignored start/valid pokes.
        add(1, 0, 8'h00, 5'b00000);
        add(0, 1, 8'hA5, 5'b11000);
        add(0, 1, 8'hFF, 5'b10110);
        add(0, 0, 8'h00, 5'b10100);
        add(1, 0, 8'h00, 5'b10110);
        add(0, 0, 8'h00, 5'b10100);
        add(0, 1, 8'h00, 5'b10100);
        add(0, 0, 8'h00, 5'b10110);
        add(0, 0, 8'h00, 5'b10100);
        add(0, 0, 8'h00, 5'b10110);
`ifdef CCFF_PARITY_EN
        add(0, 1, 8'h00, 5'b11010);
`endif
        add(1, 1, 8'hFF, 5'b10011);
        add(0, 0, 8'h00, 5'b00010);
        add(0, 1, 8'hA5, 5'b00010);

        prog_reset = 1'b1;
        step();
        step();
        chk("reset8", {busy8, i8.s_ready, sh8, head8, done8}, 0);
        chk("reset12", {busy12, i12.s_ready, sh12, head12, done12}, 0);
`ifdef CCFF_PARITY_EN
        chk("reset_err", {err8, err12}, 0);
`endif
        prog_reset = 1'b0;

        foreach (tv[i]) begin
            start8     = tv[i].st;
            i8.s_valid = tv[i].vld;
            i8.s_data  = tv[i].dat;
            chk($sformatf("vec%0d", i),
                {busy8, i8.s_ready, sh8, head8, done8}, tv[i].exp);
            step();
        end
        start8 = 1'b0;
        i8.s_valid = 1'b0;

        run12(0, "len12");
        run12(5, "stall5");

        // Reset on the third shift cycle abandons the load.
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        i8.s_valid = 1'b1;
        i8.s_data  = 8'hC3;
        step();
        i8.s_valid = 1'b0;
        step();
        step();
        chk("mid_shift3", {busy8, sh8}, 2'b11);
        prog_reset = 1'b1;
        step();
        prog_reset = 1'b0;
        chk("mid_reset", {busy8, i8.s_ready, sh8, head8, done8}, 0);

        load8(8'h5A, 8'h00, bits, n, dn);
        chk("reload_shifts", n, 8);
        chk("reload_bits", bits, 8'h5A);
        chk("reload_done", dn, 1);

`ifdef CCFF_PARITY_EN
        load8(8'h07, 8'h01, bits, n, dn);
        chk("par_ok_err", err8, 1'b0);
        chk("par_ok_bits", bits, 8'h07);
        load8(8'h07, 8'h00, bits, n, dn);
        chk("par_bad_err", err8, 1'b1);
        step();
        step();
        chk("par_err_sticky", err8, 1'b1);
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        chk("par_err_clr", err8, 1'b0);
        prog_reset = 1'b1;
        step();
        prog_reset = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
